// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared constants and types for the writeback stage: load
//             funct3 codes, FSM state type and the default datapath width.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational load-data aligner. Picks the byte/half lane from
//             the raw memory word using the low address bits and sign- or
//             zero-extends it according to funct3. Flags malformed loads
//             (unknown funct3, odd halfword address, unaligned word).
//  Revision : 1.0 - initial release
// ============================================================================
module load_extend
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data,
   output logic            err
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // lane selection: byte by addr[1:0], halfword by addr[1] only
   always_comb begin
      byte_v = rdata[7:0];
      case (addr)
         2'd0: byte_v = rdata[7:0];
         2'd1: byte_v = rdata[15:8];
         2'd2: byte_v = rdata[23:16];
         2'd3: byte_v = rdata[31:24];
         default: byte_v = rdata[7:0];
      endcase
      half_v = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   // extension and format check; unknown codes fall back to a full word
   always_comb begin
      data = rdata;
      err  = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
         F3_LH: begin
            data = {{(XLEN-16){half_v[15]}}, half_v};
            err  = addr[0];
         end
         F3_LHU: begin
            data = {{(XLEN-16){1'b0}}, half_v};
            err  = addr[0];
         end
         F3_LW: begin
            data = rdata;
            err  = (addr != 2'b00);
         end
         default: begin
            data = rdata;
            err  = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/wb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_writer
//  Purpose  : Writeback stage driving the register file write port. ALU
//             results are written one cycle after they arrive; loads stall
//             the pipeline in WAIT_LOAD until memory responds, then the
//             aligned/extended data is written the cycle after the response.
//             Optional macro WB_BYPASS_EN adds fwd_valid/fwd_addr/fwd_data,
//             a same-cycle copy of the write port for execute-stage bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_writer
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ex_valid,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_result,
   input  logic            ex_is_load,
   input  logic [2:0]      ex_funct3,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_o,
   output logic            write,
   output logic [4:0]      w_addr,
   output logic [XLEN-1:0] w_data,
   output logic            err_o
`ifdef WB_BYPASS_EN
   ,
   output logic            fwd_valid,
   output logic [4:0]      fwd_addr,
   output logic [XLEN-1:0] fwd_data
`endif
);

   wb_state_e state, state_nxt;

   logic       alu_wr;
   logic       load_accept;
   logic       load_done;

   // load context captured at accept time
   logic [4:0] ctx_rd;
   logic [2:0] ctx_funct3;
   logic [1:0] ctx_addr;

   logic [XLEN-1:0] ext_data;
   logic            ext_err;

   load_extend #(
      .XLEN (XLEN)
   ) u_load_extend (
      .funct3 (ctx_funct3),
      .addr   (ctx_addr),
      .rdata  (dmem_rdata),
      .data   (ext_data),
      .err    (ext_err)
   );

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // next-state, stall and write-event decode
   always_comb begin
      state_nxt   = state;
      stall_o     = 1'b0;
      alu_wr      = 1'b0;
      load_accept = 1'b0;
      load_done   = 1'b0;
      if (state == ST_IDLE) begin
         if (ex_valid) begin
            if (ex_is_load) begin
               stall_o     = 1'b1;
               load_accept = 1'b1;
               state_nxt   = ST_WAIT_LOAD;
            end else begin
               alu_wr = 1'b1;
            end
         end
      end else begin
         // ex_valid is deliberately ignored while a load is outstanding
         stall_o = 1'b1;
         if (dmem_rvalid) begin
            load_done = 1'b1;
            state_nxt = ST_IDLE;
         end
      end
   end

   // latch destination, width code and lane bits when a load is accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctx_rd     <= 5'd0;
         ctx_funct3 <= 3'd0;
         ctx_addr   <= 2'd0;
      end else if (load_accept) begin
         ctx_rd     <= ex_rd;
         ctx_funct3 <= ex_funct3;
         ctx_addr   <= ex_result[1:0];
      end
   end

   // registered write port; x0 writes are suppressed but still sequenced
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         write  <= 1'b0;
         w_addr <= 5'd0;
         w_data <= '0;
         err_o  <= 1'b0;
      end else begin
         write <= 1'b0;
         if (alu_wr) begin
            write  <= (ex_rd != 5'd0);
            w_addr <= ex_rd;
            w_data <= ex_result;
         end else if (load_done) begin
            write  <= (ctx_rd != 5'd0);
            w_addr <= ctx_rd;
            w_data <= ext_data;
            err_o  <= err_o | ext_err;
         end
      end
   end

`ifdef WB_BYPASS_EN
   assign fwd_valid = write;
   assign fwd_addr  = w_addr;
   assign fwd_data  = w_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_writer
//  Purpose  : Self-checking bench for wb_writer: table of load vectors,
//             hand-written ALU/reset sequences and a randomized mix checked
//             against a behavioural load model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_writer;

   logic        clk;
   logic        rstn;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result;
   logic        ex_is_load;
   logic [2:0]  ex_funct3;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stall_o;
   logic        write;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   bit err_model = 1'b0;

   wb_writer dut (
      .clk         (clk),
      .rstn        (rstn),
      .ex_valid    (ex_valid),
      .ex_rd       (ex_rd),
      .ex_result   (ex_result),
      .ex_is_load  (ex_is_load),
      .ex_funct3   (ex_funct3),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .stall_o     (stall_o),
      .write       (write),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  addr;
      logic [31:0] rdata;
      int          gap;
      logic [31:0] exp_data;
      bit          fmt_err;
   } vec_t;

   vec_t tbl [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // reference: read the architectural meaning of each load code directly
   function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] res;
      bit          bad;
      int          hofs;
      sh  = word >> (8 * a);
      res = word;
      bad = 1'b0;
      hofs = a[1] ? 16 : 0;
      case (f3)
         3'b000: res = 32'($signed(sh[7:0]));
         3'b100: res = {24'd0, sh[7:0]};
         3'b001: begin
            res = (word >> hofs) & 32'hFFFF;
            if (res[15]) res = res | 32'hFFFF_0000;
            bad = a[0];
         end
         3'b101: begin
            res = (word >> hofs) & 32'hFFFF;
            bad = a[0];
         end
         3'b010: begin
            res = word;
            bad = (a != 0);
         end
         default: begin
            res = word;
            bad = 1'b1;
         end
      endcase
      return {bad, res};
   endfunction

   task automatic do_alu(input logic [4:0] rd, input logic [31:0] res);
      ex_valid    = 1'b1;
      ex_is_load  = 1'b0;
      ex_rd       = rd;
      ex_result   = res;
      ex_funct3   = 3'($urandom);
      dmem_rvalid = 1'($urandom);
      dmem_rdata  = $urandom;
      #1 chk("alu_stall", {31'd0, stall_o}, 32'd0);
      tick();
      ex_valid    = 1'b0;
      dmem_rvalid = 1'b0;
      chk("alu_write", {31'd0, write}, {31'd0, (rd != 0)});
      if (rd != 0) begin
         chk("alu_addr", {27'd0, w_addr}, {27'd0, rd});
         chk("alu_data", w_data, res);
      end
      chk("alu_err", {31'd0, err_o}, {31'd0, err_model});
   endtask

   task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int gap,
                          input logic [31:0] exp_data, input bit fmt_err);
      // accept cycle; an rvalid here must be ignored
      ex_valid    = 1'b1;
      ex_is_load  = 1'b1;
      ex_rd       = rd;
      ex_funct3   = f3;
      ex_result   = addr;
      dmem_rvalid = 1'b1;
      dmem_rdata  = $urandom;
      #1 chk("ld_stall_accept", {31'd0, stall_o}, 32'd1);
      tick();
      chk("ld_nowrite_accept", {31'd0, write}, 32'd0);
      for (int i = 1; i < gap; i++) begin
         ex_valid    = 1'b1;
         ex_is_load  = 1'($urandom);
         ex_rd       = 5'($urandom);
         ex_result   = $urandom;
         ex_funct3   = 3'($urandom);
         dmem_rvalid = 1'b0;
         #1 chk("ld_stall_wait", {31'd0, stall_o}, 32'd1);
         tick();
         chk("ld_nowrite_wait", {31'd0, write}, 32'd0);
      end
      ex_valid    = 1'($urandom);
      ex_is_load  = 1'($urandom);
      ex_rd       = 5'($urandom);
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      #1 chk("ld_stall_rvalid", {31'd0, stall_o}, 32'd1);
      tick();
      ex_valid    = 1'b0;
      ex_is_load  = 1'b0;
      dmem_rvalid = 1'b0;
      err_model   = err_model | fmt_err;
      #1 chk("ld_stall_release", {31'd0, stall_o}, 32'd0);
      chk("ld_write", {31'd0, write}, {31'd0, (rd != 0)});
      if (rd != 0) begin
         chk("ld_addr", {27'd0, w_addr}, {27'd0, rd});
         chk("ld_data", w_data, exp_data);
      end
      chk("ld_err", {31'd0, err_o}, {31'd0, err_model});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_write"}, {31'd0, write}, 32'd0);
      chk({tag, "_waddr"}, {27'd0, w_addr}, 32'd0);
      chk({tag, "_wdata"}, w_data, 32'd0);
      chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
      chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
   endtask

   initial begin
      logic [32:0] r;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      logic [4:0]  rd;

      //          rd     f3      addr  rdata          gap exp_data       err
      tbl[0]  = '{5'd5,  3'b000, 2'd3, 32'h80FF_FF7F, 2, 32'hFFFF_FF80, 1'b0};
      tbl[1]  = '{5'd6,  3'b100, 2'd3, 32'h80FF_FF7F, 1, 32'h0000_0080, 1'b0};
      tbl[2]  = '{5'd7,  3'b000, 2'd0, 32'h1234_567F, 3, 32'h0000_007F, 1'b0};
      tbl[3]  = '{5'd8,  3'b001, 2'd2, 32'hBEEF_1234, 1, 32'hFFFF_BEEF, 1'b0};
      tbl[4]  = '{5'd9,  3'b101, 2'd2, 32'hBEEF_1234, 2, 32'h0000_BEEF, 1'b0};
      tbl[5]  = '{5'd10, 3'b101, 2'd0, 32'hBEEF_1234, 1, 32'h0000_1234, 1'b0};
      tbl[6]  = '{5'd11, 3'b001, 2'd0, 32'h0000_8001, 1, 32'hFFFF_8001, 1'b0};
      tbl[7]  = '{5'd12, 3'b010, 2'd0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0};
      tbl[8]  = '{5'd0,  3'b010, 2'd0, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1'b0};
      tbl[9]  = '{5'd13, 3'b001, 2'd1, 32'hBEEF_1234, 1, 32'h0000_1234, 1'b1};
      tbl[10] = '{5'd14, 3'b010, 2'd2, 32'h1122_3344, 2, 32'h1122_3344, 1'b1};
      tbl[11] = '{5'd15, 3'b011, 2'd1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b1};
      tbl[12] = '{5'd16, 3'b101, 2'd3, 32'h8000_0001, 1, 32'h0000_8000, 1'b1};

      rstn        = 1'b0;
      ex_valid    = 1'b0;
      ex_rd       = 5'd0;
      ex_result   = 32'd0;
      ex_is_load  = 1'b0;
      ex_funct3   = 3'd0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
      repeat (3) tick();
      chk_all_zero("reset");
      rstn = 1'b1;
      tick();

      // ALU stream: three back-to-back results, one write per cycle
      do_alu(5'd1, 32'h11);
      do_alu(5'd2, 32'h22);
      do_alu(5'd3, 32'h33);
      tick();
      chk("alu_idle_nowrite", {31'd0, write}, 32'd0);
      do_alu(5'd0, 32'hFFFF_FFFF);

      // load vectors; error rows are last so the sticky flag is checked growing
      for (int i = 0; i < 13; i++)
         do_load(tbl[i].rd, tbl[i].f3, {30'h2AAA_AAAA, tbl[i].addr}, tbl[i].rdata,
                 tbl[i].gap, tbl[i].exp_data, tbl[i].fmt_err);
      do_load(5'd17, 3'b010, 32'h100, 32'h5555_AAAA, 1, 32'h5555_AAAA, 1'b0);

      // new ALU op in the load's write cycle is accepted at once
      do_load(5'd18, 3'b100, 32'h1, 32'h0000_9900, 1, 32'h0000_0099, 1'b0);
      do_alu(5'd19, 32'h77);

      // reset while waiting for memory abandons the load
      ex_valid    = 1'b1;
      ex_is_load  = 1'b1;
      ex_rd       = 5'd20;
      ex_funct3   = 3'b010;
      ex_result   = 32'h0;
      tick();
      ex_valid = 1'b0;
      tick();
      chk("rst_mid_stall_before", {31'd0, stall_o}, 32'd1);
      rstn = 1'b0;
      err_model = 1'b0;
      #1 chk_all_zero("rst_mid");
      tick();
      rstn = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hABCD_EF01;
      tick();
      dmem_rvalid = 1'b0;
      chk_all_zero("rst_late_rvalid");
      tick();
      chk_all_zero("rst_after");

      // randomized mix against the reference model
      for (int n = 0; n < 60; n++) begin
         rd = 5'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            do_alu(rd, $urandom);
         end else begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            r  = ref_load(f3, a[1:0], d);
            do_load(rd, f3, a, d, int'($urandom_range(1, 3)), r[31:0], r[32]);
         end
      end

      tick();
      chk("final_idle_write", {31'd0, write}, 32'd0);
      chk("final_idle_stall", {31'd0, stall_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_writer.md
# wb_writer

Writeback stage driving the integer register file's single write port (`write`, `w_addr`, `w_data`). It takes completed results from the execute stage and load data returned by data memory, and aligns and sign/zero-extends load data. A load-wait state machine stalls the pipeline until memory responds. Writes reach the register file exactly one cycle after the result is available.

## Interface
- `XLEN`, 32, datapath width
- `clk` in 1: system clock
- `rstn` in 1: asynchronous active-low reset
- `ex_valid` in 1: execute stage presents a completed instruction this cycle
- `ex_rd` in 5: destination register
- `ex_result` in 32: ALU result, or load address when `ex_is_load`
- `ex_is_load` in 1: instruction is a load
- `ex_funct3` in 3: load width/sign code
- `dmem_rvalid` in 1: data memory read response valid (one-cycle pulse)
- `dmem_rdata` in 32: raw memory word
- `stall_o` out 1: hold execute and earlier stages
- `write` out 1: register file write enable
- `w_addr` out 5: register file write address
- `w_data` out 32: register file write data
- `err_o` out 1: sticky load-format error
- `fwd_valid`, `fwd_addr`, `fwd_data` out 1/5/32: bypass copy of the write port (only with `WB_BYPASS_EN`)

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, `ex_valid & ~ex_is_load`:
  - next cycle `write=1`, `w_addr=ex_rd`, `w_data=ex_result`.
- IDLE, `ex_valid & ex_is_load`:
  - latch `ex_rd`, `ex_funct3` and `ex_result[1:0]` into the load context.
  - go to WAIT_LOAD. No write.
- WAIT_LOAD:
  - `ex_valid` is ignored; the pipeline is stalled.
  - on `dmem_rvalid`: next cycle write the extended data to the latched rd, then return to IDLE.
  - no timeout; the block waits indefinitely.
- `dmem_rvalid` in IDLE is ignored: no write and no error.
- rd = 0: `write` is forced to 0 for both ALU results and loads. The FSM still sequences normally.
- Load extraction by funct3, with the lane selected by the latched `addr[1:0]`:
  - 000 LB: byte, sign-extended.
  - 100 LBU: byte, zero-extended.
  - 001 LH: half at lane `addr[1]`, sign-extended.
  - 101 LHU: half at lane `addr[1]`, zero-extended.
  - 010 LW: full word.
- Load format errors set `err_o` in the write cycle. Write data in each case:
  - any other funct3: written as LW.
  - LH/LHU with `addr[0]=1`: uses lane `addr[1]`.
  - LW with `addr[1:0]≠0`: full word, unrotated.
- `err_o` stays set until reset.
- `stall_o` (combinational):
  - high when IDLE with `ex_valid & ex_is_load`.
  - high in every WAIT_LOAD cycle, including the `dmem_rvalid` cycle.
  - low in the cycle after `dmem_rvalid`, which is the write cycle.

## Timing
- Reset: state IDLE; `write`, `w_addr`, `w_data`, `err_o` and `fwd_*` all 0; load context cleared.
- Reset asserted mid-load: the load is abandoned and no write occurs. A late `dmem_rvalid` is ignored.
- ALU latency: `ex_valid` at cycle N gives `write` high at N+1 for exactly one cycle.
- Load latency: accept at N; `dmem_rvalid` at M > N gives `write` at M+1.
  - `dmem_rvalid` at N itself, the accept cycle, is ignored (IDLE).
- Back-to-back ALU results: one write per cycle, no bubbles.
- A new `ex_valid` in the load's write cycle M+1 is accepted normally (state is IDLE).
- All outputs except `stall_o` are registered.

## Configuration
- `WB_BYPASS_EN`:
  - Defined: `fwd_valid`, `fwd_addr` and `fwd_data` mirror `write`, `w_addr` and `w_data` in the same cycle. Execute uses them to bypass the registered register-file read.
  - Undefined: these ports are absent and no bypass logic is generated.

## Structure
- Package `wb_pkg`:
  - funct3 load constants (LB, LH, LW, LBU, LHU).
  - FSM state typedef.
  - `XLEN` default.
- Sub-module `load_extend` (combinational):
  - inputs: funct3, `addr[1:0]`, `rdata`.
  - outputs: extended data and an error flag.
  - instantiated once; also reusable by the store path's tests.

## Test plan
- ALU stream:
  - stimulus: `ex_valid` on 3 consecutive cycles, rd=1,2,3, results 0x11, 0x22, 0x33.
  - required: `write` high on 3 consecutive cycles starting 1 cycle later, with matching addr/data.
- LB sign-extend:
  - stimulus: load with addr=0x...3, funct3=000; `dmem_rvalid` 2 cycles later with rdata=0x80FF_FF7F.
  - required: `stall_o` high 3 cycles; `write` with `w_data=0xFFFF_FF80`, `err_o=0`.
- LHU upper half:
  - stimulus: addr lo=2, funct3=101, rdata=0xBEEF_1234.
  - required: `w_data=0x0000_BEEF`.
- rd=0 load:
  - stimulus: rd=0, LW.
  - required: FSM waits and `stall_o` releases; `write` stays 0.
- Misaligned LH:
  - stimulus: addr lo=1.
  - required: `err_o` rises in the write cycle and stays high until `rstn` low.
- Reset mid-load:
  - stimulus: `rstn` low while in WAIT_LOAD, then `dmem_rvalid` after release.
  - required: no write; `stall_o=0`; all outputs 0.
